// File: rtl/serial_tx_arbiter_if.sv
// Byte-stream bus between NUM_REQ packet sources, the arbiter and the UART
// serial_transmitter. The arbiter uses the slave view; whatever drives the
// sources and models the transmitter's tx_ready uses the master view.
interface serial_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // Per-source byte streams; source i occupies req_data[8*i+7:8*i].
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  // Single transmitter channel.
  logic [7:0]           tx_data;
  logic                 tx_data_available;
  logic                 tx_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_ready,
    input  req_ready,
    input  tx_data,
    input  tx_data_available
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_ready,
    output req_ready,
    output tx_data,
    output tx_data_available
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of one UART serial_transmitter.
// A source is locked for a whole packet (until the byte flagged req_last is
// taken), so bytes of different packets never interleave. A gap watchdog
// abandons a locked source that goes silent mid-packet for GAP_TIMEOUT cycles.
// While locked, the transmitter side is a pure combinational view of the
// granted source; everything else (busy, grant_id, timeout_pulse) is a flop.
module serial_tx_arbiter #(
  parameter int NUM_REQ     = 4,      // 2..8 requesters
  parameter int GAP_TIMEOUT = 48000   // silent cycles before forced release, 0 = off
) (
  input  logic                 clock,
  input  logic                 reset_n,
  serial_tx_arbiter_if.slave   bus,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_pulse
);

  // Source index width; one extra bit is used for the wrap-around sum.
  localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                SUM_W     = PTR_W + 1;
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [SUM_W-1:0]  NUM_REQ_S = SUM_W'(NUM_REQ);

  // Watchdog compare value; the 16-bit counter saturates at GAP_MAX.
  localparam bit                GAP_EN    = (GAP_TIMEOUT > 0);
  localparam logic [15:0]       GAP_LIMIT = GAP_EN ? 16'(GAP_TIMEOUT - 1) : 16'hFFFF;
  localparam logic [15:0]       GAP_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  // Registered state.
  state_e              state_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [PTR_W-1:0]    grant_q;
  logic [15:0]         gap_cnt_q;
  logic                busy_q;
  logic                timeout_q;

  // Combinational decode.
  logic                locked_s;
  logic                g_valid_s;
  logic                g_last_s;
  logic                xfer_s;
  logic                last_xfer_s;
  logic                gap_fire_s;
  logic                win_found_s;
  logic [PTR_W-1:0]    win_idx_s;
  logic [PTR_W-1:0]    next_ptr_s;
  logic [PTR_W:0]      pick_s;
  logic [7:0]          tx_data_s;
  logic                tx_avail_s;
  logic [NUM_REQ-1:0]  req_ready_s;

  // Round-robin search: first valid source scanning ptr, ptr+1, ... with
  // wrap-around. Returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(
    input logic [NUM_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr
  );
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [SUM_W-1:0] sum;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= NUM_REQ_S) begin
        sum = sum - NUM_REQ_S;
      end else begin
        sum = sum;
      end
      if (!found && valid[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        idx   = sum[PTR_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Successor of a source index, wrapping NUM_REQ-1 back to 0.
  function automatic logic [PTR_W-1:0] next_index(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] n;
    if (g == LAST_IDX) begin
      n = '0;
    end else begin
      n = g + PTR_W'(1);
    end
    return n;
  endfunction

  assign locked_s    = (state_q == ST_LOCKED);
  assign pick_s      = rr_pick(bus.req_valid, rr_ptr_q);
  assign win_found_s = pick_s[PTR_W];
  assign win_idx_s   = pick_s[PTR_W-1:0];
  assign next_ptr_s  = next_index(grant_q);

  // Granted-source view and transfer / watchdog events for this cycle.
  always_comb begin
    g_valid_s   = bus.req_valid[grant_q];
    g_last_s    = bus.req_last[grant_q];
    xfer_s      = locked_s && g_valid_s && bus.tx_ready;
    last_xfer_s = xfer_s && g_last_s;
    if (GAP_EN) begin
      gap_fire_s = locked_s && !g_valid_s && (gap_cnt_q == GAP_LIMIT);
    end else begin
      gap_fire_s = 1'b0;
    end
  end

  // Transmitter-side mux: transparent path from the locked source only.
  // tx_data_available never depends on tx_ready.
  always_comb begin
    tx_data_s   = 8'h00;
    tx_avail_s  = 1'b0;
    req_ready_s = '0;
    if (locked_s) begin
      tx_data_s            = bus.req_data[{grant_q, 3'b000} +: 8];
      tx_avail_s           = g_valid_s;
      req_ready_s[grant_q] = bus.tx_ready;
    end else begin
      tx_data_s   = 8'h00;
      tx_avail_s  = 1'b0;
      req_ready_s = '0;
    end
  end

  assign bus.tx_data           = tx_data_s;
  assign bus.tx_data_available = tx_avail_s;
  assign bus.req_ready         = req_ready_s;

  assign grant_id      = 3'(grant_q);
  assign busy          = busy_q;
  assign timeout_pulse = timeout_q;

  // Arbitration FSM with gap watchdog and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      gap_cnt_q <= 16'h0000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Counter starts from zero on every entry to LOCKED.
          gap_cnt_q <= 16'h0000;
          if (win_found_s) begin
            grant_q <= win_idx_s;
            state_q <= ST_LOCKED;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        ST_LOCKED: begin
          if (last_xfer_s || gap_fire_s) begin
            // Packet done or abandoned: give the next source first chance.
            // New requests seen this cycle wait for the IDLE cycle.
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            rr_ptr_q  <= next_ptr_s;
            gap_cnt_q <= 16'h0000;
            timeout_q <= gap_fire_s;
          end else begin
            state_q <= ST_LOCKED;
            busy_q  <= 1'b1;
            // Only source silence counts; a stalled transmitter does not.
            if (g_valid_s) begin
              gap_cnt_q <= 16'h0000;
            end else if (gap_cnt_q != GAP_MAX) begin
              gap_cnt_q <= gap_cnt_q + 16'd1;
            end else begin
              gap_cnt_q <= gap_cnt_q;
            end
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          gap_cnt_q <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter (NUM_REQ=4, GAP_TIMEOUT=8). A reference model
// tracks owner / next-start / silent-run and predicts every output each cycle;
// a vector table and directed sequences cover the named scenarios, and a
// randomized phase drives queued packets from all sources.
module tb_serial_tx_arbiter;

  localparam int N    = 4;
  localparam int GAP  = 8;
  localparam int RING = 256;

  logic        clock;
  logic        reset_n;
  logic [2:0]  grant_id;
  logic        busy;
  logic        timeout_pulse;

  serial_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  serial_tx_arbiter #(.NUM_REQ(N), .GAP_TIMEOUT(GAP)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .bus           (bus),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  bit m_busy;
  int m_owner;
  int m_rr;
  int m_quiet;
  bit m_pulse;

  // Observations of the DUT.
  int act_q[$];
  int grant_log[$];
  bit prev_busy;
  bit obs_pulse;
  bit obs_xfer;

  // Source packet rings: {last, byte}.
  logic [8:0]   ring [N][RING];
  int           head [N];
  int           tail [N];
  int           pause [N];
  bit           auto_mode;
  int           ready_pct;
  int           pause_pct;
  logic [N-1:0] acc;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        txr;
    logic        e_busy;
    logic [2:0]  e_grant;
    logic        e_avail;
    logic [7:0]  e_data;
    logic [3:0]  e_ready;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int q_at(input int k);
    if (k < act_q.size()) return act_q[k];
    return -1;
  endfunction

  function automatic int g_at(input int k);
    if (k < grant_log.size()) return grant_log[k];
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (tail[i] != head[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_rr = 0; m_quiet = 0; m_pulse = 1'b0;
  endtask

  // One clock of the arbitration rules, applied to the inputs at the edge.
  task automatic model_update();
    bit any;
    bit pulse;
    int s;
    pulse = 1'b0;
    if (!m_busy) begin
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        s = (m_rr + k) % N;
        if (!any && bus.req_valid[s]) begin
          any = 1'b1;
          m_owner = s;
        end
      end
      if (any) begin
        m_busy  = 1'b1;
        m_quiet = 0;
      end
    end else if (bus.req_valid[m_owner]) begin
      m_quiet = 0;
      if (bus.tx_ready && bus.req_last[m_owner]) begin
        m_busy = 1'b0;
        m_rr   = (m_owner + 1) % N;
      end
    end else begin
      m_quiet++;
      if (m_quiet >= GAP) begin
        m_busy = 1'b0;
        m_rr   = (m_owner + 1) % N;
        pulse  = 1'b1;
      end
    end
    m_pulse = pulse;
  endtask

  task automatic push_byte(input int i, input logic [7:0] b, input logic last);
    ring[i][tail[i] % RING] = {last, b};
    tail[i]++;
  endtask

  task automatic drive_auto();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (pause[i] == 0 && tail[i] != head[i]) begin
        e = ring[i][head[i] % RING];
        bus.req_valid[i]       = 1'b1;
        bus.req_last[i]        = e[8];
        bus.req_data[i*8 +: 8] = e[7:0];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_last[i]        = 1'b0;
        bus.req_data[i*8 +: 8] = 8'h00;
      end
    end
    bus.tx_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  // Pops accepted bytes; a source may go quiet only when it is not holding an unaccepted byte.
  task automatic advance_auto();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) head[i]++;
      if (pause[i] > 0) pause[i]--;
      else if (!(bus.req_valid[i] && !acc[i]) && ($urandom_range(0, 99) < pause_pct))
        pause[i] = $urandom_range(1, 14);
    end
  endtask

  // Compare this cycle against the model, then advance one clock.
  task automatic step();
    logic [7:0]   ed;
    logic         ea;
    logic [N-1:0] er;
    #1;
    ed = 8'h00; ea = 1'b0; er = '0;
    if (m_busy) begin
      ea = bus.req_valid[m_owner];
      ed = bus.req_data[m_owner*8 +: 8];
      er[m_owner] = bus.tx_ready;
    end
    chk("busy", busy, m_busy);
    if (m_busy) chk("grant_id", grant_id, m_owner);
    chk("tx_data_available", bus.tx_data_available, ea);
    chk("tx_data", bus.tx_data, ed);
    chk("req_ready", bus.req_ready, er);
    chk("timeout_pulse", timeout_pulse, m_pulse);
    obs_pulse = timeout_pulse;
    obs_xfer  = bus.tx_data_available && bus.tx_ready;
    if (obs_xfer) act_q.push_back(int'(grant_id) * 256 + int'(bus.tx_data));
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    prev_busy = busy;
    acc = bus.req_ready & bus.req_valid;
    @(posedge clock);
    model_update();
    #1;
    if (auto_mode) begin
      advance_auto();
      drive_auto();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " grant_id"}, grant_id, 3'd0);
    chk({tag, " tx_data_available"}, bus.tx_data_available, 1'b0);
    chk({tag, " tx_data"}, bus.tx_data, 8'h00);
    chk({tag, " req_ready"}, bus.req_ready, 4'h0);
    chk({tag, " timeout_pulse"}, timeout_pulse, 1'b0);
  endtask

  // Reset with every input active to prove outputs are gated; ends at posedge+1.
  task automatic do_reset();
    auto_mode = 1'b0;
    bus.req_valid = '1; bus.req_data = '1; bus.req_last = '1; bus.tx_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    chk_all_zero("reset");
    model_reset();
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; pause[i] = 0; end
    act_q.delete(); grant_log.delete(); prev_busy = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk_all_zero("reset hold");
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_ready = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int limit, input string name);
    int n;
    n = 0;
    while ((pending() || busy) && n < limit) begin
      step();
      n++;
    end
    chk(name, (n < limit), 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL time_limit: simulation did not finish, %0d tests run", tests);
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int pulses;
    int s;
    int len;
    int exp2 [10];
    int ord2 [5];

    // {valid, data, last, tx_ready} -> {busy, grant, avail, tx_data, req_ready}
    tbl[0] = '{4'b0001, 32'h0000_0048, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
    tbl[1] = '{4'b0001, 32'h0000_0048, 4'b0000, 1'b1, 1'b1, 3'd0, 1'b1, 8'h48, 4'b0001};
    tbl[2] = '{4'b0001, 32'h0000_0069, 4'b0000, 1'b1, 1'b1, 3'd0, 1'b1, 8'h69, 4'b0001};
    tbl[3] = '{4'b0001, 32'h0000_000A, 4'b0001, 1'b1, 1'b1, 3'd0, 1'b1, 8'h0A, 4'b0001};
    tbl[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
    tbl[5] = '{4'b0011, 32'h0000_5A41, 4'b0011, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
    tbl[6] = '{4'b0011, 32'h0000_5A41, 4'b0011, 1'b1, 1'b1, 3'd1, 1'b1, 8'h5A, 4'b0010};
    tbl[7] = '{4'b0001, 32'h0000_5A41, 4'b0001, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
    tbl[8] = '{4'b0001, 32'h0000_5A41, 4'b0001, 1'b1, 1'b1, 3'd0, 1'b1, 8'h41, 4'b0001};
    tbl[9] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};

    exp2 = '{32'h001, 32'h002, 32'h111, 32'h112, 32'h221, 32'h222, 32'h331, 32'h332, 32'h003, 32'h004};
    ord2 = '{0, 1, 2, 3, 0};

    ready_pct = 100; pause_pct = 0;
    reset_n = 1'b1;
    #3;
    do_reset();

    // "Hi\n" from source 0, then the round-robin pointer favours source 1.
    for (int r = 0; r < 10; r++) begin
      bus.req_valid = tbl[r].valid;
      bus.req_data  = tbl[r].data;
      bus.req_last  = tbl[r].last;
      bus.tx_ready  = tbl[r].txr;
      #1;
      chk($sformatf("vec%0d busy", r), busy, tbl[r].e_busy);
      if (tbl[r].e_busy) chk($sformatf("vec%0d grant_id", r), grant_id, tbl[r].e_grant);
      chk($sformatf("vec%0d tx_data_available", r), bus.tx_data_available, tbl[r].e_avail);
      chk($sformatf("vec%0d tx_data", r), bus.tx_data, tbl[r].e_data);
      chk($sformatf("vec%0d req_ready", r), bus.req_ready, tbl[r].e_ready);
      step();
    end
    chk("hi byte0", q_at(0), 32'h048);
    chk("hi byte1", q_at(1), 32'h069);
    chk("hi byte2", q_at(2), 32'h00A);
    chk("rr to src1", q_at(3), 32'h15A);
    chk("single src regrant", q_at(4), 32'h041);

    // Four sources with 2-byte packets held continuously.
    do_reset();
    auto_mode = 1'b1; ready_pct = 100; pause_pct = 0;
    for (int i = 0; i < N; i++) begin
      push_byte(i, 8'(16 * i + 1), 1'b0);
      push_byte(i, 8'(16 * i + 2), 1'b1);
    end
    push_byte(0, 8'h03, 1'b0);
    push_byte(0, 8'h04, 1'b1);
    drive_auto();
    drain(100, "all4 drain");
    for (int k = 0; k < 5; k++) chk($sformatf("all4 grant%0d", k), g_at(k), ord2[k]);
    for (int k = 0; k < 10; k++) chk($sformatf("all4 byte%0d", k), q_at(k), exp2[k]);

    // Source 3 wins, pointer wraps, source 0 beats 1 and 3.
    do_reset();
    auto_mode = 1'b1;
    push_byte(3, 8'h3A, 1'b1);
    drive_auto();
    drain(50, "wrap drain1");
    grant_log.delete();
    push_byte(0, 8'h0A, 1'b1);
    push_byte(1, 8'h1A, 1'b1);
    push_byte(3, 8'h3B, 1'b1);
    drive_auto();
    drain(50, "wrap drain2");
    chk("wrap first grant", g_at(0), 0);
    chk("wrap second grant", g_at(1), 1);
    chk("wrap third grant", g_at(2), 3);

    // Gap watchdog: source 1 sends one byte then goes silent.
    do_reset();
    auto_mode = 1'b1;
    push_byte(1, 8'h77, 1'b0);
    drive_auto();
    n = 0;
    do begin step(); n++; end while (!obs_xfer && n < 10);
    chk("gap first byte", obs_xfer, 1'b1);
    push_byte(0, 8'h0C, 1'b1);
    push_byte(2, 8'h2C, 1'b1);
    drive_auto();
    n = 0;
    do begin step(); n++; end while (!obs_pulse && n < 30);
    // GAP silent cycles, then the pulse is visible the cycle after release.
    chk("gap pulse delay", n, GAP + 1);
    chk("gap next busy", busy, 1'b1);
    chk("gap next grant", grant_id, 3'd2);
    drain(50, "gap drain");
    chk("gap bytes", act_q.size(), 3);

    // Long transmitter stall is not a gap.
    do_reset();
    bus.req_valid = 4'b0001; bus.req_data = 32'h0000_0055; bus.req_last = 4'b0001; bus.tx_ready = 1'b0;
    step();
    pulses = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      pulses += int'(obs_pulse);
    end
    chk("stall no timeout", pulses, 0);
    chk("stall no byte", act_q.size(), 0);
    bus.tx_ready = 1'b1;
    step();
    chk("stall byte", q_at(0), 32'h055);
    bus.req_valid = 4'b0000;
    step();

    // Reset mid-packet.
    do_reset();
    bus.req_valid = 4'b0100; bus.req_data = 32'h0099_0000; bus.req_last = 4'b0000; bus.tx_ready = 1'b1;
    step(); step(); step();
    chk("midrst locked", busy, 1'b1);
    bus.req_valid = 4'b0101; bus.req_data = 32'h0099_0011;
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    act_q.delete(); grant_log.delete(); prev_busy = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    step();
    chk("midrst restart grant", grant_id, 3'd0);
    chk("midrst restart busy", busy, 1'b1);
    bus.req_valid = 4'b0000;
    step();
    do_reset();

    // Randomized traffic with source pauses (watchdog releases) and tx_ready stalls.
    auto_mode = 1'b1; ready_pct = 70; pause_pct = 4;
    drive_auto();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        s = $urandom_range(0, N - 1);
        if (tail[s] - head[s] < 100) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(s, 8'($urandom_range(0, 255)), (b == len - 1));
          drive_auto();
        end
      end
      step();
    end
    ready_pct = 100; pause_pct = 0;
    drain(3000, "random drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
